avg_frame_scheduler: RTL and testbench

Round-robin frame scheduler that shares one double-precision frame averager among `N_CH` interferometer sample channels. Grants one channel a whole frame (sof..eof) at a time and forwards it to the averager. Enforces the averager's maximum frame length, waits for the averager's result, then returns it tagged with channel id and beat count. Sits between the per-channel phase-sample sources and the averaging unit.

---
 rtl/avg_sched_pkg.sv | 24 ++
 rtl/avg_frame_scheduler_rr_arbiter.sv | 29 ++
 rtl/avg_frame_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_avg_frame_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_sched_pkg.sv
// Shared types and constants for the averager frame scheduler.
// Optional result watchdog is enabled with the AVG_SCHED_TIMEOUT_EN macro.
package avg_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_STREAM   = 3'd1,
      S_DRAIN    = 3'd2,
      S_WAIT_RES = 3'd3,
      S_RESULT   = 3'd4
   } state_t;

   // Beat counter / reported length width (holds MAX_LEN up to 1023)
   localparam int LEN_W = 10;

   // IEEE-754 double +0.0, returned when the averager never answers
   localparam logic [63:0] DOUBLE_ZERO = 64'h0;

   // Channel index width; never narrower than one bit
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/avg_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after ptr,
// wrapping around, and reports it both one-hot and as an index.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int CH_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [CH_W-1:0] ptr,
   input  logic            en,
   output logic [N-1:0]    gnt,
   output logic [CH_W-1:0] gnt_idx,
   output logic            gnt_vld
);

   // Scan N positions starting one past the pointer; first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (en && !gnt_vld && req[(int'(ptr) + k) % N]) begin
            gnt_vld                   = 1'b1;
            gnt_idx                   = CH_W'((int'(ptr) + k) % N);
            gnt[(int'(ptr) + k) % N]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/avg_frame_scheduler.sv
// Shares one frame averager among N_CH channels, one whole frame at a time.
// Frames longer than MAX_LEN are truncated (forced eof) and the tail drained.
// Define AVG_SCHED_TIMEOUT_EN to compile in the result watchdog.
module avg_frame_scheduler
   import avg_sched_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int C_DATA_WIDTH   = 54,
   parameter int MAX_LEN        = 1001,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_CH*C_DATA_WIDTH-1:0]   ch_data,
   input  logic [N_CH-1:0]                ch_sof,
   input  logic [N_CH-1:0]                ch_eof,
   input  logic [N_CH-1:0]                ch_valid,
   output logic [N_CH-1:0]                ch_ready,
   output logic [C_DATA_WIDTH-1:0]        avg_data,
   output logic                           avg_sof,
   output logic                           avg_eof,
   output logic                           avg_valid,
   input  logic                           avg_ready,
   input  logic [63:0]                    avg_result,
   input  logic                           avg_result_valid,
   output logic [63:0]                    res_data,
   output logic [$clog2(N_CH)-1:0]        res_ch,
   output logic [9:0]                     res_len,
   output logic                           res_valid,
   output logic                           res_err,
   output logic                           err_overlen,
   output logic                           busy
);

   localparam int CH_W = ch_w(N_CH);

   state_t                  state_q, state_d;
   logic [CH_W-1:0]         g_q, g_d;
   logic [CH_W-1:0]         ptr_q, ptr_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [N_CH-1:0]         ch_ready_q, ch_ready_d;
   logic [C_DATA_WIDTH-1:0] avg_data_q, avg_data_d;
   logic                    avg_sof_q, avg_sof_d;
   logic                    avg_eof_q, avg_eof_d;
   logic                    avg_valid_q, avg_valid_d;
   logic [63:0]             res_data_q, res_data_d;
   logic [CH_W-1:0]         res_ch_q, res_ch_d;
   logic [LEN_W-1:0]        res_len_q, res_len_d;
   logic                    res_valid_q, res_valid_d;
   logic                    err_overlen_q, err_overlen_d;
   logic                    busy_q, busy_d;

   logic [N_CH-1:0]         arb_gnt;
   logic [CH_W-1:0]         arb_idx;
   logic                    arb_vld;
   logic                    acc;
   logic [C_DATA_WIDTH-1:0] sel_data;
   logic                    sel_sof, sel_eof;
   logic [LEN_W-1:0]        cnt_inc;

`ifdef AVG_SCHED_TIMEOUT_EN
   logic [31:0]             to_cnt_q, to_cnt_d;
   logic                    res_err_q, res_err_d;
   logic                    timeout;
   assign timeout = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`endif

   // Requests are sof beats; a grant is only possible while idle and the averager is free
   rr_arbiter #(.N(N_CH), .CH_W(CH_W)) u_arb (
      .req     (ch_valid & ch_sof),
      .ptr     (ptr_q),
      .en      ((state_q == S_IDLE) && avg_ready),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // Granted channel's beat and handshake
   always_comb begin
      sel_data = ch_data[int'(g_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
      sel_sof  = ch_sof[g_q];
      sel_eof  = ch_eof[g_q];
      acc      = ch_valid[g_q] & ch_ready_q[g_q];
      cnt_inc  = cnt_q + LEN_W'(1);
   end

   // Next-state and registered-output logic for the frame FSM
   always_comb begin
      state_d       = state_q;
      g_d           = g_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      ch_ready_d    = ch_ready_q;
      avg_data_d    = avg_data_q;
      avg_sof_d     = 1'b0;
      avg_eof_d     = 1'b0;
      avg_valid_d   = 1'b0;
      res_data_d    = res_data_q;
      res_ch_d      = res_ch_q;
      res_len_d     = res_len_q;
      res_valid_d   = 1'b0;
      err_overlen_d = 1'b0;
`ifdef AVG_SCHED_TIMEOUT_EN
      to_cnt_d      = '0;
      res_err_d     = res_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (arb_vld) begin
               state_d    = S_STREAM;
               g_d        = arb_idx;
               ch_ready_d = arb_gnt;
               cnt_d      = '0;
            end
         end
         S_STREAM: begin
            // Mid-frame sof is forwarded as-is; the count keeps running
            if (acc) begin
               avg_valid_d = 1'b1;
               avg_data_d  = sel_data;
               avg_sof_d   = sel_sof;
               cnt_d       = cnt_inc;
               if (sel_eof) begin
                  avg_eof_d  = 1'b1;
                  ch_ready_d = '0;
                  state_d    = S_WAIT_RES;
               end else if (cnt_inc == LEN_W'(MAX_LEN)) begin
                  avg_eof_d     = 1'b1;
                  err_overlen_d = 1'b1;
                  state_d       = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Tail of a truncated frame is swallowed, nothing reaches the averager
            if (acc && sel_eof) begin
               ch_ready_d = '0;
               state_d    = S_WAIT_RES;
            end
         end
         S_WAIT_RES: begin
            if (avg_result_valid) begin
               res_data_d  = avg_result;
               res_ch_d    = g_q;
               res_len_d   = cnt_q;
               res_valid_d = 1'b1;
               state_d     = S_RESULT;
`ifdef AVG_SCHED_TIMEOUT_EN
               res_err_d   = 1'b0;
            end else if (timeout) begin
               res_data_d  = DOUBLE_ZERO;
               res_ch_d    = g_q;
               res_len_d   = cnt_q;
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               state_d     = S_RESULT;
            end else begin
               to_cnt_d    = to_cnt_q + 32'd1;
`endif
            end
         end
         S_RESULT: begin
            ptr_d   = g_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         g_q           <= '0;
         ptr_q         <= CH_W'(N_CH - 1);
         cnt_q         <= '0;
         ch_ready_q    <= '0;
         avg_data_q    <= '0;
         avg_sof_q     <= 1'b0;
         avg_eof_q     <= 1'b0;
         avg_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_ch_q      <= '0;
         res_len_q     <= '0;
         res_valid_q   <= 1'b0;
         err_overlen_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         g_q           <= g_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         ch_ready_q    <= ch_ready_d;
         avg_data_q    <= avg_data_d;
         avg_sof_q     <= avg_sof_d;
         avg_eof_q     <= avg_eof_d;
         avg_valid_q   <= avg_valid_d;
         res_data_q    <= res_data_d;
         res_ch_q      <= res_ch_d;
         res_len_q     <= res_len_d;
         res_valid_q   <= res_valid_d;
         err_overlen_q <= err_overlen_d;
         busy_q        <= busy_d;
      end
   end

`ifdef AVG_SCHED_TIMEOUT_EN
   // Watchdog counter and error flag for a missing averager result
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q  <= '0;
         res_err_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         res_err_q <= res_err_d;
      end
   end
   assign res_err = res_err_q;
`else
   assign res_err = 1'b0;
`endif

   assign ch_ready    = ch_ready_q;
   assign avg_data    = avg_data_q;
   assign avg_sof     = avg_sof_q;
   assign avg_eof     = avg_eof_q;
   assign avg_valid   = avg_valid_q;
   assign res_data    = res_data_q;
   assign res_ch      = res_ch_q;
   assign res_len     = res_len_q;
   assign res_valid   = res_valid_q;
   assign err_overlen = err_overlen_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_avg_frame_scheduler.sv
// Directed bench for avg_frame_scheduler with a small averager model.
// Build with AVG_SCHED_TIMEOUT_EN to exercise the result watchdog.
module tb_avg_frame_scheduler;

   localparam int N = 4;
   localparam int W = 54;

   typedef struct {
      logic [W-1:0] d;
      logic         sof;
      logic         eof;
      int           cyc;
   } beat_t;

   typedef struct {
      logic [63:0] d;
      logic [1:0]  ch;
      logic [9:0]  len;
      logic        err;
   } res_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] ch_data;
   logic [N-1:0]   ch_sof, ch_eof, ch_valid, ch_ready;
   logic [W-1:0]   avg_data;
   logic           avg_sof, avg_eof, avg_valid, avg_ready;
   logic [63:0]    avg_result = 64'h0;
   logic           avg_result_valid = 1'b0;
   logic [63:0]    res_data;
   logic [1:0]     res_ch;
   logic [9:0]     res_len;
   logic           res_valid, res_err, err_overlen, busy;

   int    vecs = 0;
   int    fails = 0;
   int    cyc_n = 0;
   int    ovl_cnt = 0;
   beat_t avg_q[$];
   res_t  res_q[$];

   real   acc_sum = 0.0;
   int    acc_n = 0;
   int    pend = 0;
   bit    model_en = 1'b1;

   avg_frame_scheduler #(
      .N_CH(N), .C_DATA_WIDTH(W), .MAX_LEN(1001), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .ch_data(ch_data), .ch_sof(ch_sof), .ch_eof(ch_eof), .ch_valid(ch_valid),
      .ch_ready(ch_ready),
      .avg_data(avg_data), .avg_sof(avg_sof), .avg_eof(avg_eof), .avg_valid(avg_valid),
      .avg_ready(avg_ready),
      .avg_result(avg_result), .avg_result_valid(avg_result_valid),
      .res_data(res_data), .res_ch(res_ch), .res_len(res_len), .res_valid(res_valid),
      .res_err(res_err), .err_overlen(err_overlen), .busy(busy)
   );

   always #5 clk = ~clk;

   // Capture averager-side beats, tagged results and overlength pulses
   always @(negedge clk) begin
      cyc_n++;
      if (avg_valid === 1'b1) avg_q.push_back('{avg_data, avg_sof, avg_eof, cyc_n});
      if (res_valid === 1'b1) res_q.push_back('{res_data, res_ch, res_len, res_err});
      if (err_overlen === 1'b1) ovl_cnt++;
   end

   // Averager model: running mean, restarts on sof, answers 12 cycles after eof
   always @(negedge clk) begin
      avg_result_valid = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0 && model_en) begin
            avg_result_valid = 1'b1;
            avg_result       = $realtobits(acc_sum / acc_n);
         end
      end
      if (avg_valid === 1'b1) begin
         if (avg_sof) begin
            acc_sum = 0.0;
            acc_n   = 0;
         end
         acc_sum = acc_sum + $itor(avg_data[31:0]);
         acc_n++;
         if (avg_eof) pend = 12;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive n beats (base, base+1, ...) on channel c; optionally check 1-cycle forwarding
   task automatic send_beats(input int c, input int n, input int base,
                             input bit last_eof, input bit chk_lat);
      int cyc;
      for (int i = 0; i < n; i++) begin
         ch_valid[c]        = 1'b1;
         ch_sof[c]          = (i == 0);
         ch_eof[c]          = last_eof && (i == n - 1);
         ch_data[c*W +: W]  = W'(base + i);
         cyc = 0;
         while (ch_ready[c] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         if (cyc >= 200) begin
            check("handshake_timeout", 64'(ch_ready[c]), 64'd1);
            break;
         end
         @(negedge clk);
         if (chk_lat) check("fwd_latency", {9'd0, avg_valid, avg_data}, {9'd0, 1'b1, W'(base + i)});
      end
      ch_valid[c] = 1'b0;
      ch_sof[c]   = 1'b0;
      ch_eof[c]   = 1'b0;
   endtask

   task automatic wait_res(input int n);
      int cyc;
      cyc = 0;
      while (res_q.size() < n && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("res_arrived", 64'(res_q.size()), 64'(n));
   endtask

   initial begin
      int cyc;
      int eofs;
      rst       = 1'b1;
      avg_ready = 1'b1;
      ch_data   = '0;
      ch_sof    = '0;
      ch_eof    = '0;
      ch_valid  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ctl", 64'({ch_ready, avg_valid, avg_sof, avg_eof, res_valid, res_err, err_overlen, busy}), 64'd0);
      check("rst_avg_data", 64'(avg_data), 64'd0);
      check("rst_res_data", res_data, 64'd0);
      check("rst_res_tag", 64'({res_ch, res_len}), 64'd0);
      rst = 1'b0;

      // Single frame on ch1: values 1..5, mean 3.0
      send_beats(1, 5, 1, 1'b1, 1'b1);
      wait_res(1);
      check("single_nbeats", 64'(avg_q.size()), 64'd5);
      if (avg_q.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            check("single_beat", {8'd0, avg_q[i].sof, avg_q[i].eof, avg_q[i].d},
                  {8'd0, (i == 0), (i == 4), W'(i + 1)});
         end
         check("single_no_bubble", 64'(avg_q[4].cyc - avg_q[0].cyc), 64'd4);
      end
      check("single_res_data", res_q[0].d, 64'h4008000000000000);
      check("single_res_tag", 64'({res_q[0].err, res_q[0].ch, res_q[0].len}), {51'd0, 1'b0, 2'd1, 10'd5});

      // Fairness: everyone holds a one-beat frame; first grant after reset is ch0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      avg_q.delete();
      res_q.delete();
      for (int c = 0; c < N; c++) begin
         ch_data[c*W +: W] = W'(100 + c);
      end
      ch_valid = 4'hF;
      ch_sof   = 4'hF;
      ch_eof   = 4'hF;
      for (int n = 0; n < 5; n++) begin
         cyc = 0;
         while (ch_ready === 4'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         check("fair_grant", 64'(ch_ready), 64'(4'b0001 << (n % 4)));
         check("fair_prev_done", 64'(res_q.size()), 64'(n));
         @(negedge clk);
      end
      ch_valid = '0;
      ch_sof   = '0;
      ch_eof   = '0;
      wait_res(5);
      if (res_q.size() == 5) begin
         for (int n = 0; n < 5; n++) begin
            check("fair_res_tag", 64'({res_q[n].ch, res_q[n].len}), 64'({2'(n % 4), 10'd1}));
         end
      end

      // Overlength: ch2 sends 1010 beats, truncated at 1001, tail drained
      avg_q.delete();
      res_q.delete();
      ovl_cnt = 0;
      send_beats(2, 1010, 1, 1'b1, 1'b0);
      wait_res(1);
      check("ovl_nbeats", 64'(avg_q.size()), 64'd1001);
      eofs = 0;
      foreach (avg_q[i]) if (avg_q[i].eof) eofs++;
      check("ovl_eof_count", 64'(eofs), 64'd1);
      if (avg_q.size() == 1001) check("ovl_forced_eof", 64'({avg_q[1000].eof, avg_q[1000].d}), {9'd0, 1'b1, W'(1001)});
      check("ovl_pulses", 64'(ovl_cnt), 64'd1);
      check("ovl_res_tag", 64'({res_q[0].ch, res_q[0].len}), 64'({2'd2, 10'd1001}));
      check("ovl_res_data", res_q[0].d, $realtobits(501.0));

      // Reset mid-STREAM after 3 beats, then a clean 2-beat ch3 frame
      send_beats(0, 3, 40, 1'b0, 1'b1);
      check("mid_busy", 64'({busy, ch_ready}), 64'({1'b1, 4'b0001}));
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ctl", 64'({ch_ready, avg_valid, avg_sof, avg_eof, res_valid, res_err, err_overlen, busy}), 64'd0);
      check("mid_rst_data", 64'(avg_data), 64'd0);
      check("mid_rst_res", res_data, 64'd0);
      check("mid_rst_tag", 64'({res_ch, res_len}), 64'd0);
      rst = 1'b0;
      res_q.delete();
      send_beats(3, 2, 10, 1'b1, 1'b1);
      wait_res(1);
      check("ch3_res_tag", 64'({res_q[0].ch, res_q[0].len}), 64'({2'd3, 10'd2}));
      check("ch3_res_data", res_q[0].d, 64'h4025000000000000);

      // Averager busy holds off the grant
      res_q.delete();
      avg_ready   = 1'b0;
      ch_valid[0] = 1'b1;
      ch_sof[0]   = 1'b1;
      ch_eof[0]   = 1'b1;
      ch_data[0 +: W] = W'(7);
      repeat (4) @(negedge clk);
      check("busy_no_grant", 64'({busy, ch_ready}), 64'd0);
      avg_ready = 1'b1;
      @(negedge clk);
      check("busy_grant_next", 64'(ch_ready), 64'(4'b0001));
      @(negedge clk);
      ch_valid = '0;
      ch_sof   = '0;
      ch_eof   = '0;
      wait_res(1);
      check("busy_res", res_q[0].d, 64'h401C000000000000);

      // Averager never answers
      res_q.delete();
      model_en = 1'b0;
      send_beats(1, 1, 5, 1'b1, 1'b0);
`ifdef AVG_SCHED_TIMEOUT_EN
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("to_delay", 64'(cyc), 64'd16);
      check("to_res", {res_err, res_data[62:0]}, 64'h8000000000000000);
      check("to_tag", 64'({res_ch, res_len}), 64'({2'd1, 10'd1}));
`else
      repeat (40) @(negedge clk);
      #1;
      check("wait_forever", 64'({res_q.size() != 0, busy, res_err}), 64'(3'b010));
`endif
      model_en = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
